// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: serialises the low len bits of pattern onto a, MSB first,
// holding each bit for period+1 cycles, then pulses done for one cycle.
//
// Ports:
//   clk       - single clock, rising edge
//   rstn      - synchronous active-low reset
//   start     - transmit request, accepted in IDLE and DONE
//   pattern   - bits to send, right-aligned (WIDTH)
//   len       - number of bits to send; 0 or >WIDTH means WIDTH (LEN_W)
//   period    - each bit is held period+1 cycles (4)
//   repeat_en - only with SERIAL_PATTERN_GEN_REPEAT_EN: restart the pattern
//               instead of finishing ("repeat" is a reserved word in SV)
//   a         - registered serial data bit
//   a_valid   - high while a carries a pattern bit
//   busy      - high in SEND
//   done      - one-cycle pulse after the last bit
//
// Optional feature macro: SERIAL_PATTERN_GEN_REPEAT_EN
module serial_pattern_gen #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [3:0]       period,
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
  input  logic             repeat_en,
`endif
  output logic             a,
  output logic             a_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] pat_q;      // left-aligned copy, reloaded on repeat
  logic [WIDTH-1:0] shreg;      // remaining bits of the current pass, MSB next
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bits_left;  // bits still to send after the current one
  logic [3:0]       period_q;
  logic [3:0]       per_cnt;
  logic             rpt_c;

  logic [LEN_W-1:0] len_c;
  logic [LEN_W-1:0] shamt_c;
  logic [WIDTH-1:0] pat_al_c;

`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
  assign rpt_c = repeat_en;
`else
  assign rpt_c = 1'b0;
`endif

  // Clamp len and left-align the pattern so the first bit sits at the MSB.
  always_comb begin
    len_c = len;
    if (len == '0 || len > LEN_W'(WIDTH)) len_c = LEN_W'(WIDTH);
    shamt_c  = LEN_W'(WIDTH) - len_c;
    pat_al_c = pattern << shamt_c;
  end

  // FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      pat_q     <= '0;
      shreg     <= '0;
      len_q     <= '0;
      bits_left <= '0;
      period_q  <= '0;
      per_cnt   <= '0;
      a         <= 1'b0;
      a_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state   <= IDLE;
          a       <= 1'b0;
          a_valid <= 1'b0;
          busy    <= 1'b0;
          if (start) begin
            pat_q     <= pat_al_c;
            shreg     <= pat_al_c << 1;
            a         <= pat_al_c[WIDTH-1];
            len_q     <= len_c;
            bits_left <= len_c - LEN_W'(1);
            period_q  <= period;
            per_cnt   <= '0;
            a_valid   <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (per_cnt != period_q) begin
            per_cnt <= per_cnt + 4'd1;
          end else begin
            per_cnt <= '0;
            if (bits_left != '0) begin
              bits_left <= bits_left - LEN_W'(1);
              a         <= shreg[WIDTH-1];
              shreg     <= shreg << 1;
            end else if (rpt_c) begin
              // Seamless restart: no DONE cycle, a_valid stays high.
              bits_left <= len_q - LEN_W'(1);
              a         <= pat_q[WIDTH-1];
              shreg     <= pat_q << 1;
            end else begin
              state   <= DONE;
              a       <= 1'b0;
              a_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed testbench for serial_pattern_gen (16-bit default configuration).
module tb_serial_pattern_gen;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic [3:0]  period;
  logic        repeat_en;
  logic        a, a_valid, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_pattern_gen #(.WIDTH(16), .LEN_W(5)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .period    (period),
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
    .repeat_en (repeat_en),
`endif
    .a         (a),
    .a_valid   (a_valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] outs();
    return {a, a_valid, busy, done};
  endfunction

  // Issue a start with the given payload; returns positioned after the capture edge.
  task automatic go(input logic [15:0] p, input logic [4:0] l, input logic [3:0] per);
    pattern = p;
    len     = l;
    period  = per;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    // Scramble inputs after capture: must have no effect.
    pattern = ~p;
    len     = 5'd3;
    period  = 4'd7;
  endtask

  // Check n cycles of serial data (exp MSB first), then the done pulse.
  // ign_at >= 0 pulses start at that cycle to check it is ignored.
  task automatic check_stream(input string tag, input logic [63:0] exp, input int n, input int ign_at);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_bit%0d", tag, i), 32'(outs()), 32'({exp[n-1-i], 3'b110}));
      if (i == ign_at) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check({tag, "_done"}, 32'(outs()), 32'h1);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b1; pattern = 16'hFFFF; len = 5'd4; period = 4'd0; repeat_en = 1'b0;

    // Reset held with start asserted: nothing may transmit.
    tick(); check("rst_c1", 32'(outs()), 32'h0);
    tick(); check("rst_c2", 32'(outs()), 32'h0);
    rstn = 1'b1; start = 1'b0;
    tick(); check("idle", 32'(outs()), 32'h0);

    // 4 bits of 0xB, one bit per cycle, then back to idle.
    go(16'h000B, 5'd4, 4'd0);
    check_stream("b4", 64'b1011, 4, -1);
    tick(); check("b4_idle", 32'(outs()), 32'h0);

    // period=2: each bit held three cycles.
    go(16'h0002, 5'd2, 4'd2);
    check_stream("p2", 64'b111000, 6, -1);
    tick(); check("p2_idle", 32'(outs()), 32'h0);

    // len=0 clamps to 16; start mid-SEND ignored; start in DONE is back-to-back.
    go(16'h8001, 5'd0, 4'd0);
    check_stream("l0", 64'h8001, 16, 5);
    pattern = 16'h0003; len = 5'd2; period = 4'd0; start = 1'b1;
    tick(); start = 1'b0;
    check_stream("b2b", 64'b11, 2, -1);
    tick(); check("b2b_idle", 32'(outs()), 32'h0);

    // len above WIDTH also clamps to 16.
    go(16'hC002, 5'd20, 4'd0);
    check_stream("l20", 64'hC002, 16, -1);
    tick(); check("l20_idle", 32'(outs()), 32'h0);

    // Reset in the middle of a transmission.
    go(16'h000B, 5'd4, 4'd0);
    check("mr_bit0", 32'(outs()), 32'he);
    tick();
    check("mr_bit1", 32'(outs()), 32'h6);
    rstn = 1'b0;
    tick(); check("mr_rst", 32'(outs()), 32'h0);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); check($sformatf("mr_quiet%0d", i), 32'(outs()), 32'h0);
    end

`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
    // Repeat: 0,1,0,1,... without gaps; dropping repeat finishes the pass.
    repeat_en = 1'b1;
    go(16'h0001, 5'd2, 4'd0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rp_bit%0d", i), 32'(outs()), 32'({i[0], 3'b110}));
      if (i == 5) repeat_en = 1'b0;
      tick();
    end
    check("rp_done", 32'(outs()), 32'h1);
    tick(); check("rp_idle", 32'(outs()), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
